voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Schedules MIDI note events from midi_ctrl onto a fixed pool of synth voices in synth2.
- On note-on it picks a voice, in this order: retrigger the same note, then the lowest free slot, then steal the oldest voice.
- On note-off it finds the voice holding that note and channel and releases it.
- Sits between midi_ctrl and synth2 in the clk96 domain.

Parameters:
- NUM_VOICES, 8, number of voice slots; must be 2..16.
- IDX_W, 3, width of the voice index; must be >= clog2(NUM_VOICES).
- AGE_W, 8, width of each per-voice age counter; saturates at its maximum.

Ports:
- clk96  in  1  system clock (96 MHz).
- rst  in  1  synchronous, active-high reset.
- note_pressed  in  1  one-cycle note-on strobe.
- note_released  in  1  one-cycle note-off strobe.
- note  in  7  MIDI note number, valid with a strobe.
- velocity  in  7  MIDI velocity, valid with a strobe.
- channel  in  4  MIDI channel, valid with a strobe.
- sustain  in  1  sustain pedal level; used only with the optional feature.
- voice_start  out  1  one-cycle pulse: start voice voice_idx.
- voice_stop  out  1  one-cycle pulse: stop voice voice_idx.
- voice_idx  out  IDX_W  target voice; valid with voice_start or voice_stop.
- voice_note  out  7  note for voice_start.
- voice_velocity  out  7  velocity for voice_start.
- active  out  NUM_VOICES  per-voice active mask.
- busy  out  1  high while the FSM is not in IDLE.
- drop  out  1  one-cycle pulse: an event was discarded.

Behaviour:
- Reset values: all outputs 0, active mask 0, all ages 0, pending slot empty, FSM in IDLE. Reset asserted mid-scan aborts the scan; no pulse is issued.
- Per-voice state: active, note[6:0], chan[3:0], age[AGE_W-1:0].
- Event decode:
  - note_pressed with velocity==0 is treated as a note-off.
  - note_pressed and note_released in the same cycle: the press is accepted; the release goes to the pending slot.
- Event queue: one-deep pending register.
  - An event arriving while busy, or on the cycle the FSM leaves ISSUE, is stored in pending if pending is empty.
  - If pending is full, the event is discarded and drop pulses.
  - IDLE always serves pending before any new input.
- FSM states: IDLE, SCAN, ISSUE.
  - IDLE: latch the event (note, velocity, channel, type), set scan pointer i=0, go to SCAN.
  - SCAN: examine voice i, one voice per cycle, for exactly NUM_VOICES cycles; then go to ISSUE.
  - Note-on scan records, with the lowest index winning ties:
    - match: active, same note and same channel;
    - free: first inactive voice;
    - oldest: active voice with the maximum age.
  - Note-off scan records the first active voice with the same note and channel.
  - ISSUE (one cycle), note-on:
    - target = match, else free, else oldest;
    - if the target was active (steal or retrigger), pulse voice_stop and voice_start in the same cycle;
    - otherwise pulse voice_start only;
    - write note, chan, active=1, age=0 into the target; every other active voice increments its age, saturating at max.
  - ISSUE, note-off:
    - if a voice was found: pulse voice_stop and clear its active bit;
    - if none was found: no pulse, no drop.
  - After ISSUE the FSM returns to IDLE.
- Latency: strobe at cycle 0; ISSUE outputs are registered and appear at cycle NUM_VOICES+2.
- Throughput: one event per NUM_VOICES+2 cycles. At 96 MHz this is far faster than the MIDI byte rate, so pending overflow occurs only with burst stimulus.
- active is updated on the same edge that drives the pulses.

Optional Feature:
- Macro: VOICE_ALLOC_SUSTAIN_EN.
- With the macro defined:
  - a note-off matched while sustain==1 sets that voice's held bit instead of pulsing voice_stop;
  - held voices stay active and may still be stolen or retriggered, which clears held;
  - on a sustain falling edge, a RELEASE state stops each held voice, lowest index first, one voice_stop pulse per cycle, clearing active and held;
  - new events queue in pending during RELEASE; busy stays high.
- Without the macro: the sustain input is ignored, no held bits or RELEASE state are built, and note-off always stops the voice.

Test Plan:
- Reset, then note-on (note 60, vel 100, ch 0) -> voice_start, idx 0, note 60, vel 100 at cycle 10 (NUM_VOICES=8); active=8'h01.
- Press notes 60..67 on ch 0, then 68 -> the 9th press steals voice 0 (age 7): voice_stop and voice_start together, idx 0, note 68.
- Press note 60 twice on ch 0 -> second press retriggers idx 0; active unchanged; no new slot used.
- Note-off note 61 with no match -> no pulse; note-on with vel 0 for an active note 60 -> voice_stop on that idx.
- Three strobes on consecutive cycles while busy -> first served, second pending, third causes a drop pulse; the second is issued after the first completes.
- With VOICE_ALLOC_SUSTAIN_EN: sustain=1, press and release notes 60 and 62 -> no voice_stop; sustain falls -> stops idx 0 then idx 1 on consecutive cycles.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: maps MIDI note-on/note-off events onto a fixed pool of
// synth voices. Note-on picks retrigger > lowest free slot > oldest voice;
// note-off releases the voice holding that note and channel.
// Each event takes NUM_VOICES+2 cycles (IDLE, NUM_VOICES x SCAN, ISSUE).
// A one-deep pending slot absorbs one event while busy; further events drop.
// Optional macro VOICE_ALLOC_SUSTAIN_EN adds a sustain pedal. While the pedal
// is down, a note-off holds its voice. When the pedal is released, a RELEASE
// state stops every held voice, one per cycle.
// Handshake: there is no backpressure. Strobes are accepted every cycle. An
// event that can be neither served nor queued is signalled by the drop pulse.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int IDX_W      = 3,
    parameter int AGE_W      = 8
) (
    input  logic                  clk96,
    input  logic                  rst,
    input  logic                  note_pressed,
    input  logic                  note_released,
    input  logic [6:0]            note,
    input  logic [6:0]            velocity,
    input  logic [3:0]            channel,
    input  logic                  sustain,
    output logic                  voice_start,
    output logic                  voice_stop,
    output logic [IDX_W-1:0]      voice_idx,
    output logic [6:0]            voice_note,
    output logic [6:0]            voice_velocity,
    output logic [NUM_VOICES-1:0] active,
    output logic                  busy,
    output logic                  drop
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    localparam logic [1:0] ST_RELEASE = 2'd3;
`endif
    // Event word layout: {is_note_on, note, velocity, channel}
    localparam int               EV_W     = 19;
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] scan_i;
    logic             cur_on;
    logic [6:0]       cur_note;
    logic [6:0]       cur_vel;
    logic [3:0]       cur_chan;

    logic             match_found, free_found, old_found;
    logic [IDX_W-1:0] match_idx, free_idx, old_idx;
    logic [AGE_W-1:0] old_age;

    logic [6:0]       v_note [NUM_VOICES];
    logic [3:0]       v_chan [NUM_VOICES];
    logic [AGE_W-1:0] v_age  [NUM_VOICES];

    logic             pend_valid;
    logic [EV_W-1:0]  pend_ev;

    logic             prim_valid, sec_valid;
    logic [EV_W-1:0]  prim_ev, sec_ev;
    logic             go_rel, consume, direct, slot_free;
    logic             qa_valid, qb_valid;
    logic [EV_W-1:0]  qa_ev;

    logic             scan_hit;
    logic [IDX_W-1:0] tgt;
    logic             tgt_was_active;

    assign busy = (state != ST_IDLE);

`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic [NUM_VOICES-1:0] held;
    logic                  sus_q, rel_req, rel_now, rel_last;
    logic [IDX_W-1:0]      rel_idx;

    assign rel_now = rel_req | (sus_q & ~sustain);
    assign go_rel  = (state == ST_IDLE) && rel_now && (|held);

    // Pick the lowest-index held voice and flag whether it is the last one
    always_comb begin
        rel_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (held[i]) rel_idx = IDX_W'(i);
        end
        rel_last = ((held & ~(NUM_VOICES'(1) << rel_idx)) == '0);
    end

    // Track the pedal and remember a release that happened while busy
    always_ff @(posedge clk96) begin
        if (rst) begin
            sus_q   <= 1'b0;
            rel_req <= 1'b0;
        end else begin
            sus_q   <= sustain;
            rel_req <= (state != ST_IDLE) && rel_now;
        end
    end
`else
    logic unused_sustain;
    assign unused_sustain = sustain;
    assign go_rel         = 1'b0;
`endif

    // Decode strobes into a primary event and a possible second (release) event
    always_comb begin
        prim_valid = note_pressed | note_released;
        prim_ev    = {note_pressed && (velocity != 7'd0), note, velocity, channel};
        sec_valid  = note_pressed & note_released;
        sec_ev     = {1'b0, note, velocity, channel};
    end

    // Decide which incoming events are served directly, queued or dropped
    always_comb begin
        consume   = (state == ST_IDLE) && !go_rel && pend_valid;
        direct    = (state == ST_IDLE) && !go_rel && !pend_valid && prim_valid;
        qa_valid  = direct ? sec_valid : prim_valid;
        qa_ev     = direct ? sec_ev : prim_ev;
        qb_valid  = direct ? 1'b0 : sec_valid;
        slot_free = !pend_valid || consume;
    end

    // One-deep pending slot and the drop pulse
    always_ff @(posedge clk96) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_ev    <= '0;
            drop       <= 1'b0;
        end else begin
            drop <= qb_valid || (qa_valid && !slot_free);
            if (qa_valid && slot_free) begin
                pend_valid <= 1'b1;
                pend_ev    <= qa_ev;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Compare the voice under the scan pointer with the latched event
    always_comb begin
        scan_hit = active[scan_i] && (v_note[scan_i] == cur_note) &&
                   (v_chan[scan_i] == cur_chan);
    end

    // Note-on target: retrigger, else lowest free, else oldest
    always_comb begin
        if (match_found)     tgt = match_idx;
        else if (free_found) tgt = free_idx;
        else                 tgt = old_idx;
        tgt_was_active = match_found || !free_found;
    end

    // Main FSM: latch event, scan voices, issue pulses and update voice state
    always_ff @(posedge clk96) begin
        if (rst) begin
            state          <= ST_IDLE;
            scan_i         <= '0;
            cur_on         <= 1'b0;
            cur_note       <= '0;
            cur_vel        <= '0;
            cur_chan       <= '0;
            match_found    <= 1'b0;
            free_found     <= 1'b0;
            old_found      <= 1'b0;
            match_idx      <= '0;
            free_idx       <= '0;
            old_idx        <= '0;
            old_age        <= '0;
            active         <= '0;
            voice_start    <= 1'b0;
            voice_stop     <= 1'b0;
            voice_idx      <= '0;
            voice_note     <= '0;
            voice_velocity <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                v_note[i] <= '0;
                v_chan[i] <= '0;
                v_age[i]  <= '0;
            end
`ifdef VOICE_ALLOC_SUSTAIN_EN
            held <= '0;
`endif
        end else begin
            voice_start <= 1'b0;
            voice_stop  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    scan_i      <= '0;
                    match_found <= 1'b0;
                    free_found  <= 1'b0;
                    old_found   <= 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                    if (go_rel) begin
                        state <= ST_RELEASE;
                    end else
`endif
                    if (pend_valid) begin
                        {cur_on, cur_note, cur_vel, cur_chan} <= pend_ev;
                        state <= ST_SCAN;
                    end else if (prim_valid) begin
                        {cur_on, cur_note, cur_vel, cur_chan} <= prim_ev;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_hit && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_i;
                    end
                    if (!active[scan_i] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_i;
                    end
                    if (active[scan_i] && (!old_found || (v_age[scan_i] > old_age))) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_i;
                        old_age   <= v_age[scan_i];
                    end
                    if (scan_i == LAST_IDX) state <= ST_ISSUE;
                    else                    scan_i <= scan_i + 1'b1;
                end
                ST_ISSUE: begin
                    state <= ST_IDLE;
                    if (cur_on) begin
                        voice_start    <= 1'b1;
                        voice_stop     <= tgt_was_active;
                        voice_idx      <= tgt;
                        voice_note     <= cur_note;
                        voice_velocity <= cur_vel;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == tgt) begin
                                active[i] <= 1'b1;
                                v_note[i] <= cur_note;
                                v_chan[i] <= cur_chan;
                                v_age[i]  <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                                held[i]   <= 1'b0;
`endif
                            end else if (active[i] && (v_age[i] != AGE_MAX)) begin
                                v_age[i] <= v_age[i] + 1'b1;
                            end
                        end
                    end else if (match_found) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        if (sustain) begin
                            held[match_idx] <= 1'b1;
                        end else begin
                            voice_stop        <= 1'b1;
                            voice_idx         <= match_idx;
                            active[match_idx] <= 1'b0;
                            held[match_idx]   <= 1'b0;
                        end
`else
                        voice_stop        <= 1'b1;
                        voice_idx         <= match_idx;
                        active[match_idx] <= 1'b0;
`endif
                    end
                end
`ifdef VOICE_ALLOC_SUSTAIN_EN
                ST_RELEASE: begin
                    voice_stop      <= 1'b1;
                    voice_idx       <= rel_idx;
                    active[rel_idx] <= 1'b0;
                    held[rel_idx]   <= 1'b0;
                    if (rel_last) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (NUM_VOICES=8).
// Each event is fed to a behavioural voice-pool model that applies the
// allocation rules directly; expected issue words go through exp_q.
`timescale 1ns/1ps
module tb_voice_allocator;
    localparam int NV      = 8;
    localparam int IW      = 3;
    localparam int AGE_MAX = 255;
    localparam int W       = 2 + IW + 7 + 7 + NV;

    logic          clk96 = 1'b0;
    logic          rst, note_pressed, note_released, sustain;
    logic [6:0]    note, velocity;
    logic [3:0]    channel;
    logic          voice_start, voice_stop, busy, drop;
    logic [IW-1:0] voice_idx;
    logic [6:0]    voice_note, voice_velocity;
    logic [NV-1:0] active;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    bit m_active[NV];
    bit m_held[NV];
    int m_note[NV];
    int m_chan[NV];
    int m_age[NV];

    voice_allocator #(.NUM_VOICES(NV), .IDX_W(IW), .AGE_W(8)) dut (
        .clk96(clk96), .rst(rst), .note_pressed(note_pressed),
        .note_released(note_released), .note(note), .velocity(velocity),
        .channel(channel), .sustain(sustain), .voice_start(voice_start),
        .voice_stop(voice_stop), .voice_idx(voice_idx), .voice_note(voice_note),
        .voice_velocity(voice_velocity), .active(active), .busy(busy), .drop(drop)
    );

    // Free-running 100 MHz-ish clock (period is irrelevant to the checks)
    always #5 clk96 = ~clk96;

    task automatic tick();
        @(posedge clk96);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [NV-1:0] model_mask();
        logic [NV-1:0] m;
        m = '0;
        for (int i = 0; i < NV; i++) m[i] = m_active[i];
        return m;
    endfunction

    function automatic logic [W-1:0] pack(input bit st, input bit sp, input int idx,
                                          input int n, input int v, input logic [NV-1:0] m);
        logic [IW-1:0] fi;
        logic [6:0]    fn, fv;
        fi = (st || sp) ? IW'(idx) : '0;
        fn = st ? 7'(n) : 7'd0;
        fv = st ? 7'(v) : 7'd0;
        return {st, sp, fi, fn, fv, m};
    endfunction

    function automatic logic [W-1:0] obs();
        logic [IW-1:0] fi;
        logic [6:0]    fn, fv;
        fi = (voice_start || voice_stop) ? voice_idx : '0;
        fn = voice_start ? voice_note : 7'd0;
        fv = voice_start ? voice_velocity : 7'd0;
        return {voice_start, voice_stop, fi, fn, fv, active};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 0; m_held[i] = 0; m_note[i] = 0; m_chan[i] = 0; m_age[i] = 0;
        end
    endtask

    // Apply one event to the voice pool and produce the expected issue word
    task automatic model_event(input bit on, input int n, input int v, input int c,
                               output logic [W-1:0] e);
        int tgt;
        bit st, sp;
        tgt = -1; st = 0; sp = 0;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_active[i] && m_note[i] == n && m_chan[i] == c) tgt = i;
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_active[i]) tgt = i;
            if (tgt < 0) begin
                tgt = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
            end
            st = 1;
            sp = m_active[tgt];
            for (int i = 0; i < NV; i++)
                if (i != tgt && m_active[i] && m_age[i] < AGE_MAX) m_age[i]++;
            m_active[tgt] = 1; m_note[tgt] = n; m_chan[tgt] = c; m_age[tgt] = 0; m_held[tgt] = 0;
        end else begin
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && m_active[i] && m_note[i] == n && m_chan[i] == c) tgt = i;
            if (tgt >= 0) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                if (sustain) m_held[tgt] = 1;
                else begin sp = 1; m_active[tgt] = 0; m_held[tgt] = 0; end
`else
                sp = 1;
                m_active[tgt] = 0;
`endif
            end
        end
        e = pack(st, sp, tgt, n, v, model_mask());
    endtask

    task automatic strobe(input bit press, input bit rel, input int n, input int v, input int c);
        note_pressed = press; note_released = rel;
        note = 7'(n); velocity = 7'(v); channel = 4'(c);
        tick();
        note_pressed = 0; note_released = 0;
    endtask

    task automatic do_reset();
        rst = 1; note_pressed = 0; note_released = 0; sustain = 0;
        note = 0; velocity = 0; channel = 0;
        wait_cycles(2);
        rst = 0;
        model_reset();
        exp_q.delete();
    endtask

    // One isolated event: quiet for cycles 1..9, issue word at cycle 10
    task automatic run_event(input bit press, input bit rel, input int n, input int v,
                             input int c, input string name);
        logic [W-1:0] e, got;
        bit quiet;
        model_event(press && v != 0, n, v, c, e);
        exp_q.push_back(e);
        quiet = 1;
        strobe(press, rel, n, v, c);
        for (int k = 1; k <= 9; k++) begin
            if (voice_start !== 1'b0 || voice_stop !== 1'b0 || drop !== 1'b0 || busy !== 1'b1)
                quiet = 0;
            tick();
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL %s quiet: early pulse or busy low before issue cycle", name);
        end
        got = obs();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s issue: got %h expected %h", name, got, e);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] zero_w;
        bit quiet;
        do_reset();
        zero_w = '0;
        checks++;
        if ({obs(), voice_idx, voice_note, voice_velocity} !== {zero_w, 3'd0, 7'd0, 7'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h/%h/%h expected all 0", obs(), voice_idx, voice_note, voice_velocity);
        end
        checks++;
        if ({busy, drop} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy_drop: got %b%b expected 00", busy, drop);
        end
        run_event(1, 0, 50, 90, 2, "pre_reset");
        strobe(1, 0, 51, 91, 2);
        wait_cycles(3);
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        checks++;
        if ({active, busy, voice_idx, voice_note, voice_velocity} !== '0) begin
            errors++;
            $display("FAIL midscan_reset_state: got act=%h busy=%b note=%0d vel=%0d expected 0",
                     active, busy, voice_note, voice_velocity);
        end
        quiet = 1;
        for (int k = 0; k < 12; k++) begin
            if (voice_start !== 1'b0 || voice_stop !== 1'b0 || active !== '0) quiet = 0;
            tick();
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midscan_reset_abort: pulse or active seen after reset, expected none");
        end
    endtask

    task automatic test_first_note();
        do_reset();
        run_event(1, 0, 60, 100, 0, "first_note");
        checks++;
        if ({voice_start, voice_idx, voice_note, voice_velocity, active} !==
            {1'b1, 3'd0, 7'd60, 7'd100, 8'h01}) begin
            errors++;
            $display("FAIL first_note_fixed: got start=%b idx=%0d note=%0d vel=%0d act=%h expected 1/0/60/100/01",
                     voice_start, voice_idx, voice_note, voice_velocity, active);
        end
    endtask

    task automatic test_steal();
        do_reset();
        for (int n = 60; n < 68; n++) run_event(1, 0, n, 64, 0, "fill");
        run_event(1, 0, 68, 64, 0, "steal");
        checks++;
        if ({voice_start, voice_stop, voice_idx, voice_note} !== {1'b1, 1'b1, 3'd0, 7'd68}) begin
            errors++;
            $display("FAIL steal_fixed: got start=%b stop=%b idx=%0d note=%0d expected 1/1/0/68",
                     voice_start, voice_stop, voice_idx, voice_note);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        run_event(1, 0, 60, 100, 0, "retrig_first");
        run_event(1, 0, 60, 80, 0, "retrig_second");
        checks++;
        if ({voice_start, voice_stop, voice_idx, active} !== {1'b1, 1'b1, 3'd0, 8'h01}) begin
            errors++;
            $display("FAIL retrig_fixed: got start=%b stop=%b idx=%0d act=%h expected 1/1/0/01",
                     voice_start, voice_stop, voice_idx, active);
        end
    endtask

    task automatic test_note_off();
        do_reset();
        run_event(1, 0, 60, 100, 0, "off_setup");
        run_event(0, 1, 61, 0, 0, "off_nomatch");
        run_event(1, 0, 60, 0, 0, "vel0_off");
        checks++;
        if ({voice_start, voice_stop, voice_idx, active} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL vel0_fixed: got start=%b stop=%b idx=%0d act=%h expected 0/1/0/00",
                     voice_start, voice_stop, voice_idx, active);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ea, eb;
        do_reset();
        model_event(1, 60, 10, 0, ea);
        model_event(1, 62, 20, 0, eb);
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        note_pressed = 1; note = 60; velocity = 10; channel = 0;
        tick();
        note = 62; velocity = 20;
        tick();
        note = 64; velocity = 30;
        tick();
        note_pressed = 0;
        checks++;
        if (drop !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drop: got %b expected 1 at cycle 3", drop);
        end
        tick();
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop_width: got %b expected 0 at cycle 4", drop);
        end
        wait_cycles(6);
        ea = exp_q.pop_front();
        checks++;
        if (obs() !== ea) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", obs(), ea);
        end
        wait_cycles(10);
        eb = exp_q.pop_front();
        checks++;
        if (obs() !== eb) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", obs(), eb);
        end
    endtask

    task automatic test_press_release_same();
        logic [W-1:0] ea, eb;
        do_reset();
        model_event(1, 70, 50, 3, ea);
        model_event(0, 70, 50, 3, eb);
        strobe(1, 1, 70, 50, 3);
        wait_cycles(9);
        checks++;
        if (obs() !== ea) begin
            errors++;
            $display("FAIL same_cycle_press: got %h expected %h", obs(), ea);
        end
        wait_cycles(10);
        checks++;
        if (obs() !== eb) begin
            errors++;
            $display("FAIL same_cycle_release: got %h expected %h", obs(), eb);
        end
    endtask

    task automatic test_random();
        bit press;
        int n, c, v;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            press = ($urandom_range(0, 9) < 7);
            n = 60 + int'($urandom_range(0, 5));
            c = int'($urandom_range(0, 1));
            v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            run_event(press, !press, n, v, c, "random");
        end
    endtask

`ifdef VOICE_ALLOC_SUSTAIN_EN
    task automatic test_sustain();
        do_reset();
        sustain = 1;
        run_event(1, 0, 60, 100, 0, "sus_on60");
        run_event(1, 0, 62, 100, 0, "sus_on62");
        run_event(0, 1, 60, 0, 0, "sus_off60");
        run_event(0, 1, 62, 0, 0, "sus_off62");
        sustain = 0;
        tick();
        checks++;
        if ({voice_stop, busy} !== 2'b01) begin
            errors++;
            $display("FAIL sus_enter: got stop=%b busy=%b expected 0/1", voice_stop, busy);
        end
        tick();
        checks++;
        if ({voice_stop, voice_idx, active} !== {1'b1, 3'd0, 8'h02}) begin
            errors++;
            $display("FAIL sus_rel0: got stop=%b idx=%0d act=%h expected 1/0/02", voice_stop, voice_idx, active);
        end
        tick();
        checks++;
        if ({voice_stop, voice_idx, active} !== {1'b1, 3'd1, 8'h00}) begin
            errors++;
            $display("FAIL sus_rel1: got stop=%b idx=%0d act=%h expected 1/1/00", voice_stop, voice_idx, active);
        end
        tick();
        checks++;
        if ({voice_stop, busy} !== 2'b00) begin
            errors++;
            $display("FAIL sus_done: got stop=%b busy=%b expected 0/0", voice_stop, busy);
        end
        model_reset();
    endtask
`else
    task automatic test_sustain();
        bit quiet;
        do_reset();
        sustain = 1;
        run_event(1, 0, 60, 100, 0, "sus_ign_on");
        run_event(0, 1, 60, 0, 0, "sus_ign_off");
        sustain = 0;
        quiet = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (voice_stop !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL sus_ignored: activity after pedal release, expected none");
        end
    endtask
`endif

    initial begin
        rst = 1; note_pressed = 0; note_released = 0; sustain = 0;
        note = 0; velocity = 0; channel = 0;
        test_reset();
        test_first_note();
        test_steal();
        test_retrigger();
        test_note_off();
        test_back_to_back();
        test_press_release_same();
        test_sustain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
